// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM-subset main controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] SRCA_RN   = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Per-state Moore decode before ALU decode and PCS are folded in.
    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       alu_wb;
        logic       memw;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> instruction register / datapath bundle.
interface multicycle_ctrl_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;

    modport master (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUControl, FlagW, PCS, RegW, MemW
    );

    modport slave (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUControl, FlagW, PCS, RegW, MemW
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Combinational ALU decoder: ALUControl/FlagW from cmd and S, plus NoWrite for RegW suppression.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [5:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);
    logic [3:0] cmd;
    logic       s;
    logic [1:0] ctl;
    logic [1:0] fw;

    assign cmd = Funct[4:1];
    assign s   = Funct[0];

    // NoWrite depends only on cmd: it is consumed in ALUWB, where ALUOp is already 0.
    always_comb begin
        ctl     = ALU_ADD;
        fw      = 2'b00;
        NoWrite = 1'b0;
        case (cmd)
            CMD_ADD: begin ctl = ALU_ADD; fw = {s, s};    end
            CMD_SUB: begin ctl = ALU_SUB; fw = {s, s};    end
            CMD_AND: begin ctl = ALU_AND; fw = {s, 1'b0}; end
            CMD_ORR: begin ctl = ALU_ORR; fw = {s, 1'b0}; end
            CMD_CMP: begin ctl = ALU_SUB; fw = 2'b11; NoWrite = 1'b1; end
            default: NoWrite = 1'b1;
        endcase
    end

    assign ALUControl = ALUOp ? ctl : ALU_ADD;
    assign FlagW      = ALUOp ? fw  : 2'b00;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_ctrl_fsm_if.master  bus
);
    state_t state, state_next;
    ctrl_t  c;
    logic   no_write;
    logic   regw;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = bus.Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            FETCH: begin
                c.irwrite = 1'b1; c.nextpc = 1'b1;
                c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALU;
            end
            DECODE: begin
                c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALU;
            end
            MEMADR: c.alusrcb = SRCB_IMM;
            MEMRD:  c.adrsrc = 1'b1;
            MEMWB:  begin c.resultsrc = RES_RDATA; c.regw = 1'b1; end
            MEMWR:  begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECR:  begin c.aluop = 1'b1; c.alusrcb = SRCB_RM; end
            EXECI:  begin c.aluop = 1'b1; c.alusrcb = SRCB_IMM; end
            ALUWB:  c.alu_wb = 1'b1;
            BRANCH: begin
                c.alusrcb = SRCB_IMM; c.resultsrc = RES_ALU; c.branch = 1'b1;
            end
            default: c = '0;
        endcase
        // Reset may be asserted from any state; present FETCH muxes with every write disabled.
        if (!reset) begin
            c = '0;
            c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALU;
        end
    end

    alu_decoder u_alu_dec (
        .ALUOp      (c.aluop),
        .Funct      (bus.Funct),
        .ALUControl (bus.ALUControl),
        .FlagW      (bus.FlagW),
        .NoWrite    (no_write)
    );

    assign regw          = c.regw | (c.alu_wb & ~no_write);
    assign bus.RegW      = regw;
    assign bus.PCS       = (regw & (bus.Rd == 4'hF)) | c.branch;
    assign bus.IRWrite   = c.irwrite;
    assign bus.NextPC    = c.nextpc;
    assign bus.AdrSrc    = c.adrsrc;
    assign bus.ALUSrcA   = c.alusrca;
    assign bus.ALUSrcB   = c.alusrcb;
    assign bus.ResultSrc = c.resultsrc;
    assign bus.MemW      = c.memw;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench: per-instruction expected output sequences built from the instruction class.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    multicycle_ctrl_fsm_if ifc ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,PCS,RegW,MemW}
    logic [15:0] obs;
    assign obs = {ifc.IRWrite, ifc.NextPC, ifc.AdrSrc, ifc.ALUSrcA, ifc.ALUSrcB,
                  ifc.ResultSrc, ifc.ALUControl, ifc.FlagW, ifc.PCS, ifc.RegW, ifc.MemW};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] vec(input logic ir, input logic np, input logic adr,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] rs, input logic [1:0] ac,
                                        input logic [1:0] fw, input logic pcs,
                                        input logic rw, input logic mw);
        return {ir, np, adr, sa, sb, rs, ac, fw, pcs, rw, mw};
    endfunction

    // Data-processing semantics: ALU op, flag writes, whether the result is written back.
    task automatic alu_model(input logic [3:0] cmd, input logic s,
                             output logic [1:0] ac, output logic [1:0] fw, output logic wr);
        case (cmd)
            4'b0100: begin ac = 2'b00; fw = {s, s};    wr = 1'b1; end
            4'b0010: begin ac = 2'b01; fw = {s, s};    wr = 1'b1; end
            4'b0000: begin ac = 2'b10; fw = {s, 1'b0}; wr = 1'b1; end
            4'b1100: begin ac = 2'b11; fw = {s, 1'b0}; wr = 1'b1; end
            4'b1010: begin ac = 2'b01; fw = 2'b11;     wr = 1'b0; end
            default: begin ac = 2'b00; fw = 2'b00;     wr = 1'b0; end
        endcase
    endtask

    localparam logic [15:0] RST_V = 16'b0_0_0_01_10_10_00_00_0_0_0;

    // Starts at a negedge inside FETCH; abort_at >= 0 asserts reset in that cycle instead.
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input int abort_at);
        logic [15:0] q[$];
        logic [1:0] ac, fw;
        logic wr, rdpc;
        rdpc = (rd == 4'hF);
        q.push_back(vec(1, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        q.push_back(vec(0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        if (op == 2'b01) begin
            q.push_back(vec(0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
            if (funct[0]) begin
                q.push_back(vec(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
                q.push_back(vec(0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, rdpc, 1, 0));
            end else
                q.push_back(vec(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1));
        end else if (op == 2'b10) begin
            q.push_back(vec(0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0));
        end else if (op == 2'b00) begin
            alu_model(funct[4:1], funct[0], ac, fw, wr);
            q.push_back(vec(0, 0, 0, 2'b00, funct[5] ? 2'b01 : 2'b00, 2'b00, ac, fw, 0, 0, 0));
            q.push_back(vec(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, wr & rdpc, wr, 0));
        end
        foreach (q[i]) begin
            if (i == 0) begin
                ifc.Op = 2'($urandom); ifc.Funct = 6'($urandom); ifc.Rd = 4'($urandom);
            end else begin
                ifc.Op = op; ifc.Funct = funct; ifc.Rd = rd;
            end
            if (i == abort_at) begin
                reset = 1'b0;
                #1 chk({name, "_abort"}, obs, RST_V);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            #1 chk($sformatf("%s_c%0d", name, i + 1), obs, q[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.Op = 2'b01; ifc.Funct = 6'b011001; ifc.Rd = 4'hF;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk("reset", obs, RST_V);
        end
        @(negedge clk);
        reset = 1'b1;

        run_instr("adds",  2'b00, 6'b001001, 4'd1,  -1);
        run_instr("ldr",   2'b01, 6'b011001, 4'hF,  -1);
        run_instr("str",   2'b01, 6'b011000, 4'd3,  -1);
        run_instr("b",     2'b10, 6'b100000, 4'd0,  -1);
        run_instr("cmp",   2'b00, 6'b110101, 4'd0,  -1);
        run_instr("undef", 2'b11, 6'b111111, 4'hF,  -1);
        run_instr("ldr_rst", 2'b01, 6'b011001, 4'd2, 3);
        run_instr("after", 2'b00, 6'b000001, 4'hF,  -1);
        run_instr("orr_pc", 2'b00, 6'b011000, 4'hF, -1);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] op;
            logic [5:0] funct;
            logic [3:0] rd;
            int ab;
            logic [3:0] cmds [5];
            cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
            op    = 2'($urandom);
            funct = 6'($urandom);
            if ($urandom_range(0, 3) != 0) funct[4:1] = cmds[$urandom_range(0, 4)];
            rd    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            ab    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            run_instr("rnd", op, funct, rd, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle main controller for the ARM-subset processor.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath muxes and the unconditioned write requests (PCS, RegW, MemW, FlagW) that the conditional-logic block gates with CondEx.
- Sits between the instruction register fields and the conditional-logic/datapath; pure Moore FSM plus a combinational ALU decoder.

Parameters:
- none (instruction-set subset and encodings fixed by the shared package)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets)
- Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  input  6  Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S for data-processing / L for memory
- Rd  input  4  Instr[15:12], destination register
- IRWrite  output  1  instruction register load enable
- NextPC  output  1  PC update request (ORed with PCSrc in datapath)
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  output  2  00=Rn, 01=PC
- ALUSrcB  output  2  00=Rm, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut reg, 01=ReadData, 10=ALU result
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagW  output  2  [1]=write N,Z; [0]=write C,V
- PCS  output  1  PC-write-by-instruction request
- RegW  output  1  register-file write request
- MemW  output  1  data memory write request

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Reset: reset==0 at a rising edge forces state=FETCH; this overrides any in-flight instruction with no completion.
- While reset==0, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced 0. Mux selects follow FETCH decode.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (treated as NOP, no writes).
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Moore outputs; all unlisted outputs are 0 / select 00:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUOp=1, ALUSrcB=00.
  - EXECI: ALUOp=1, ALUSrcB=01.
  - ALUWB: RegW=1 unless cmd=CMP.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - When ALUOp=0: ALUControl=00 and FlagW=00.
  - When ALUOp=1, cmd 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01.
  - Any other cmd: ALUControl=00, FlagW=00, RegW suppressed in ALUWB.
  - FlagW[1]=S; FlagW[0]=S & (cmd is ADD/SUB/CMP).
  - CMP always writes flags (FlagW=11 regardless of S) and never RegW.
- PCS = (RegW & Rd==4'hF) | Branch, evaluated combinationally each cycle.
- Latency in cycles from entering FETCH: data-processing 4, LDR 5, STR 4, B 3, undefined 2.
- Op/Funct/Rd are sampled from the IR. They are only required stable from DECODE onward; values during FETCH are don't-care.

Decomposition:
- Shared package ctrl_pkg holds:
  - enum state_t.
  - Op encodings (OP_DP, OP_MEM, OP_BR).
  - cmd constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP).
  - ALUSrcA/ALUSrcB/ResultSrc select constants.
- One sub-module alu_decoder:
  - inputs ALUOp, Funct, Branch-free.
  - outputs ALUControl, FlagW and a NoWrite bit used to suppress RegW.
- State register plus next-state/output logic stay in multicycle_ctrl_fsm.

Test Plan:
- reset=0 for 2 cycles, then release: state=FETCH; IRWrite=1 and NextPC=1 in the first cycle after release; RegW=MemW=0 during reset.
- ADDS R1,R2,R3 (Op=00, Funct=001001, Rd=1): states FETCH,DECODE,EXECR,ALUWB. EXECR: ALUControl=00, FlagW=11. ALUWB: RegW=1, PCS=0. Back in FETCH at cycle 5.
- LDR (Op=01, Funct=011001, Rd=15): FETCH,DECODE,MEMADR,MEMRD,MEMWB. MEMWB: RegW=1, ResultSrc=01, PCS=1.
- STR (Op=01, Funct[0]=0): MEMWR reached in cycle 4 with MemW=1, AdrSrc=1, RegW=0.
- B (Op=10): BRANCH in cycle 3 with PCS=1, ALUSrcB=01, ResultSrc=10; FETCH in cycle 4. CMP R1,#5 (Funct=110101): FlagW=11, ALUControl=01, RegW=0 in ALUWB.
- reset=0 asserted during MEMRD of an LDR: next state FETCH, MemW/RegW never asserted for that LDR. Op=11: DECODE->FETCH with no write enables.
